memory_map_pipe: RTL and testbench
==================================

Name: memory_map_pipe

Overview:
- Parametrised, pipelined successor to the two-PE NTT bank/address mapper.
- Maps LANES read/write addresses per beat onto conflict-free memory banks: bank index BI and in-bank address BA.
- Adds valid/ready flow control with back-pressure, a per-PE mode/offset inversion mask, and same-beat bank-conflict detection with a saturating counter.
- Sits between the address generator and the banked coefficient RAMs.

Parameters:
- PE_NUM, 2: number of PEs. LANES = 2*PE_NUM; lane 2k is ie of PE k, lane 2k+1 is io of PE k.
- ADDR_W, 8: width of each logical address.
- MAP, 3: bank-index width; 2^MAP banks.
- P_SHIFT, 2: left shift applied to the high-bit parity.
- P_CONST, 2: constant added to BI when effective mode=1.
- INV_MASK, 2'b10: PE_NUM bits. Bit k=1 means PE k inverts mode and offset under the PWM opcodes.
- PWM_OP0, 2'd2 and PWM_OP1, 2'd3: opcodes that enable inversion.
- CNT_W, 16: conflict-counter width.
- BA_W (derived, ADDR_W-MAP+1): width of each BA.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous active-low reset
- in_valid  input  1  input beat valid
- in_ready  output  1  block can accept a beat
- opcode  input  2  operation code for the beat
- mode  input  1  bank-rotation select for the beat
- offset  input  1  BA MSB (ping/pong half) for the beat
- addr_in  input  LANES*ADDR_W  lane addresses; lane i at bits [i*ADDR_W +: ADDR_W]
- out_valid  output  1  output beat valid
- out_ready  input  1  downstream accepts the beat
- bi_out  output  LANES*MAP  bank indices, packed like addr_in
- ba_out  output  LANES*BA_W  bank addresses, packed like addr_in
- conflict  output  1  at least two lanes of the output beat share a bank
- conflict_cnt  output  CNT_W  count of conflicting beats transferred
- cnt_clr  input  1  synchronous clear of conflict_cnt

Behaviour:
- Reset (rst=0, asynchronous): s1_valid=0, s2_valid=0, out_valid=0, bi_out=0, ba_out=0, conflict=0, conflict_cnt=0.
- Stage 1 (S1) registers addr_in, opcode, mode and offset.
- Stage 2 (S2) computes the mapping and the conflict flag and registers them as outputs. Latency is exactly 2 cycles from the in_valid&in_ready edge to out_valid when there is no stall.
- Flow control:
  - s2_load = ~s2_valid | out_ready.
  - s1_adv = s1_valid & s2_load.
  - in_ready = ~s1_valid | s2_load.
  - Full throughput is 1 beat/cycle. No beat is dropped or duplicated.
  - While out_valid=1 and out_ready=0, all outputs hold stable.
- Per-lane effective flags:
  - inv = INV_MASK[PE(lane)] & (opcode==PWM_OP0 | opcode==PWM_OP1).
  - m = mode^inv.
  - o = offset^inv.
- Bank index:
  - BI = (a[MAP-1:0] + (parity(a[ADDR_W-1:MAP]) << P_SHIFT) + (m ? P_CONST : 0)) mod 2^MAP.
  - Sums wrap with no carry out.
- Bank address: BA = {o, a[ADDR_W-1:MAP]}, BA_W bits.
- Conflict: set if any pair i<j of the LANES BI values in the beat is equal. It is registered alongside that beat's BI.
- Counter:
  - Increments by 1 on each cycle with out_valid & out_ready & conflict.
  - Saturates at 2^CNT_W-1.
  - cnt_clr=1 forces 0 next cycle and has priority over a simultaneous increment.
- Bubbles: out_valid falls when S2 is consumed and S1 is empty. Outputs keep their last values while invalid.
- Reset mid-stream: in-flight beats are discarded and all outputs return to reset values immediately.

Test Plan:
- Defaults, lane0 addr 0x0B, mode=0, offset=0, opcode=0 -> 2 cycles later: BI0=7, BA0=6'h01. With mode=1: BI0=(7+2) mod 8=1, showing wrap.
- opcode=PWM_OP0, mode=0, offset=0, all lanes 0x0B -> lanes 0,1 (PE0): BI=7, BA=0x01. Lanes 2,3 (PE1): BI=1, BA=0x21. Same beat with opcode=1 -> all lanes BI=7, BA=0x01.
- Lanes {0x00,0x0C,0x01,0x02} -> BIs {0,0,1,2}; conflict=1 and conflict_cnt=1 after transfer. Lanes {0x00,0x08,0x01,0x02} -> BIs {0,4,1,2}; conflict=0.
- 8 back-to-back beats, out_ready=1 -> 8 consecutive out_valid cycles starting cycle 2, in order. Then hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 after 2 further accepted beats, outputs stable, no loss after release.
- conflict_cnt preloaded near max with CNT_W=4: 16 conflicting beats -> saturates at 15. cnt_clr asserted coincident with a conflicting transfer -> 0.
- Assert rst=0 with both stages valid -> out_valid, outputs and counter drop to 0 asynchronously. After release, the first new beat appears exactly 2 cycles after acceptance.

Source files
------------

// File: rtl/memory_map_pipe.sv
// memory_map_pipe: two-stage pipelined bank/address mapper for the NTT PEs.
// Each beat carries LANES = 2*PE_NUM logical addresses (lane 2k = ie of PE k,
// lane 2k+1 = io of PE k). Every lane is mapped to a bank index (bi) and an
// in-bank address (ba); a beat whose lanes hit the same bank is flagged and
// counted.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-low reset
//   in_valid/ready  input handshake; opcode, mode, offset, addr_in per beat
//   out_valid/ready output handshake; bi_out, ba_out, conflict per beat
//   conflict_cnt    saturating count of conflicting beats transferred
//   cnt_clr         synchronous clear of conflict_cnt (wins over increment)
module memory_map_pipe #(
  parameter int unsigned         PE_NUM   = 2,
  parameter int unsigned         ADDR_W   = 8,
  parameter int unsigned         MAP      = 3,
  parameter int unsigned         P_SHIFT  = 2,
  parameter int unsigned         P_CONST  = 2,
  parameter logic [PE_NUM-1:0]   INV_MASK = 2'b10,
  parameter logic [1:0]          PWM_OP0  = 2'd2,
  parameter logic [1:0]          PWM_OP1  = 2'd3,
  parameter int unsigned         CNT_W    = 16,
  localparam int unsigned        LANES    = 2 * PE_NUM,
  localparam int unsigned        BA_W     = ADDR_W - MAP + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [1:0]                opcode,
  input  logic                      mode,
  input  logic                      offset,
  input  logic [LANES*ADDR_W-1:0]   addr_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*MAP-1:0]      bi_out,
  output logic [LANES*BA_W-1:0]     ba_out,
  output logic                      conflict,
  output logic [CNT_W-1:0]          conflict_cnt,
  input  logic                      cnt_clr
);

  logic                    s1_valid;
  logic                    s2_valid;
  logic [1:0]              s1_opcode;
  logic                    s1_mode;
  logic                    s1_offset;
  logic [LANES*ADDR_W-1:0] s1_addr;

  logic                    s2_load;
  logic                    s1_adv;

  logic                    pwm_op;
  logic [MAP-1:0]          lane_bi [LANES];
  logic [LANES*MAP-1:0]    bi_next;
  logic [LANES*BA_W-1:0]   ba_next;
  logic                    conflict_next;

  // S2 can take a new beat when empty or when its beat leaves this cycle;
  // S1 can take one when empty or when it hands its beat to S2.
  assign s2_load   = ~s2_valid | out_ready;
  assign s1_adv    = s1_valid & s2_load;
  assign in_ready  = ~s1_valid | s2_load;
  assign out_valid = s2_valid;

  // Stage 1: capture the beat
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid  <= 1'b0;
      s1_opcode <= '0;
      s1_mode   <= 1'b0;
      s1_offset <= 1'b0;
      s1_addr   <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_opcode <= opcode;
        s1_mode   <= mode;
        s1_offset <= offset;
        s1_addr   <= addr_in;
      end
    end
  end

  assign pwm_op = (s1_opcode == PWM_OP0) || (s1_opcode == PWM_OP1);

  // Per-lane mapping
  for (genvar lane = 0; lane < LANES; lane++) begin : g_lane
    logic [ADDR_W-1:0]     a;
    logic [ADDR_W-MAP-1:0] hi;
    logic                  inv;
    logic                  m;
    logic                  o;

    assign a   = s1_addr[lane*ADDR_W +: ADDR_W];
    assign hi  = a[ADDR_W-1:MAP];
    assign inv = INV_MASK[lane/2] & pwm_op;
    assign m   = s1_mode ^ inv;
    assign o   = s1_offset ^ inv;

    // MAP-bit arithmetic gives the mod 2^MAP wrap for free
    assign lane_bi[lane] = a[MAP-1:0]
                         + (MAP'(^hi) << P_SHIFT)
                         + (m ? MAP'(P_CONST) : '0);

    assign bi_next[lane*MAP +: MAP]   = lane_bi[lane];
    assign ba_next[lane*BA_W +: BA_W] = {o, hi};
  end

  always_comb begin
    conflict_next = 1'b0;
    for (int unsigned i = 0; i < LANES; i++) begin
      for (int unsigned j = i + 1; j < LANES; j++) begin
        if (lane_bi[i] == lane_bi[j]) conflict_next = 1'b1;
      end
    end
  end

  // Stage 2: registered outputs; data only moves with a real beat so the
  // last values persist across bubbles and stalls
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid <= 1'b0;
      bi_out   <= '0;
      ba_out   <= '0;
      conflict <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_adv) begin
        bi_out   <= bi_next;
        ba_out   <= ba_next;
        conflict <= conflict_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      conflict_cnt <= '0;
    end else if (cnt_clr) begin
      conflict_cnt <= '0;
    end else if (out_valid && out_ready && conflict && (conflict_cnt != '1)) begin
      conflict_cnt <= conflict_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_memory_map_pipe.sv
// Bench for memory_map_pipe: a beat-level reference model (queue of expected
// beats plus a counter model) checked every cycle, plus literal expectations.
module tb_memory_map_pipe;

  localparam int unsigned PE_NUM  = 2;
  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned MAP     = 3;
  localparam int unsigned P_SHIFT = 2;
  localparam int unsigned P_CONST = 2;
  localparam logic [1:0]  INV_MASK = 2'b10;
  localparam logic [1:0]  PWM_OP0 = 2'd2;
  localparam logic [1:0]  PWM_OP1 = 2'd3;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned LANES   = 2 * PE_NUM;
  localparam int unsigned BA_W    = ADDR_W - MAP + 1;

  logic                    clk;
  logic                    rst;
  logic                    in_valid;
  logic                    in_ready;
  logic [1:0]              opcode;
  logic                    mode;
  logic                    offset;
  logic [LANES*ADDR_W-1:0] addr_in;
  logic                    out_valid;
  logic                    out_ready;
  logic [LANES*MAP-1:0]    bi_out;
  logic [LANES*BA_W-1:0]   ba_out;
  logic                    conflict;
  logic [CNT_W-1:0]        conflict_cnt;
  logic                    cnt_clr;

  memory_map_pipe #(
    .PE_NUM(PE_NUM), .ADDR_W(ADDR_W), .MAP(MAP), .P_SHIFT(P_SHIFT),
    .P_CONST(P_CONST), .INV_MASK(INV_MASK), .PWM_OP0(PWM_OP0),
    .PWM_OP1(PWM_OP1), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .mode(mode), .offset(offset), .addr_in(addr_in),
    .out_valid(out_valid), .out_ready(out_ready), .bi_out(bi_out),
    .ba_out(ba_out), .conflict(conflict), .conflict_cnt(conflict_cnt),
    .cnt_clr(cnt_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [LANES*MAP-1:0]  bi;
    logic [LANES*BA_W-1:0] ba;
    logic                  cf;
  } beat_t;

  beat_t       exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cnt_model = 0;
  int          xfers = 0;
  int          run = 0;
  int          last_run = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference mapping from the arithmetic rules, on plain integers
  function automatic beat_t model(input logic [1:0] op, input logic md, input logic off,
                                  input logic [LANES*ADDR_W-1:0] addrs);
    beat_t b;
    int bis[LANES];
    b.bi = '0;
    b.ba = '0;
    b.cf = 1'b0;
    for (int lane = 0; lane < LANES; lane++) begin
      int a   = int'(addrs[lane*ADDR_W +: ADDR_W]);
      int hi  = a / (1 << MAP);
      int inv = (INV_MASK[lane/2] && (op == PWM_OP0 || op == PWM_OP1)) ? 1 : 0;
      int m   = int'(md) ^ inv;
      int o   = int'(off) ^ inv;
      int par = $countones(hi) % 2;
      bis[lane] = (a % (1 << MAP) + par * (1 << P_SHIFT) + m * P_CONST) % (1 << MAP);
      b.bi[lane*MAP +: MAP]   = MAP'(bis[lane]);
      b.ba[lane*BA_W +: BA_W] = BA_W'(o * (1 << (ADDR_W - MAP)) + hi);
    end
    for (int i = 0; i < LANES; i++)
      for (int j = i + 1; j < LANES; j++)
        if (bis[i] == bis[j]) b.cf = 1'b1;
    return b;
  endfunction

  // Compare process: once per cycle, away from the active edge
  always @(negedge clk) begin
    if (rst) begin
      check("in_ready", 64'(in_ready), 64'(!(exp_q.size() == 2 && !out_ready)));
      if (out_valid) begin
        run++;
        if (exp_q.size() == 0) begin
          check("spurious_valid", 64'(out_valid), 64'd0);
        end else begin
          check("bi_out", 64'(bi_out), 64'(exp_q[0].bi));
          check("ba_out", 64'(ba_out), 64'(exp_q[0].ba));
          check("conflict", 64'(conflict), 64'(exp_q[0].cf));
        end
      end else if (run != 0) begin
        last_run = run;
        run = 0;
      end
      check("conflict_cnt", 64'(conflict_cnt), 64'(cnt_model));
      if (cnt_clr)
        cnt_model = 0;
      else if (out_valid && out_ready && exp_q.size() > 0 && exp_q[0].cf
               && cnt_model < (1 << CNT_W) - 1)
        cnt_model++;
      if (out_valid && out_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        xfers++;
      end
      if (in_valid && in_ready)
        exp_q.push_back(model(opcode, mode, offset, addr_in));
    end
  end

  // Present a beat and hold it until accepted; returns at posedge+1
  task automatic send(input logic [1:0] op, input logic md, input logic off,
                      input logic [LANES*ADDR_W-1:0] addrs);
    bit done = 0;
    opcode = op; mode = md; offset = off; addr_in = addrs; in_valid = 1'b1;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (in_ready) done = 1;
      @(posedge clk); #1;
    end
    if (!done) check("send_timeout", 64'd0, 64'd1);
  endtask

  // Single beat into an empty pipeline; returns while it is on the outputs
  task automatic send_one(input logic [1:0] op, input logic md, input logic off,
                          input logic [LANES*ADDR_W-1:0] addrs);
    send(op, md, off, addrs);
    in_valid = 1'b0;
    check("lat_cycle1", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check("lat_cycle2", 64'(out_valid), 64'd1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LANES*ADDR_W-1:0] v;
    int acc;
    int x0;

    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
    opcode = '0; mode = 1'b0; offset = 1'b0; addr_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_bi", 64'(bi_out), 64'd0);
    check("rst_ba", 64'(ba_out), 64'd0);
    check("rst_conflict", 64'(conflict), 64'd0);
    check("rst_cnt", 64'(conflict_cnt), 64'd0);
    #1 rst = 1'b1;
    idle(2);

    // Basic mapping and mode-driven wrap on lane 0
    send_one(2'd0, 1'b0, 1'b0, {8'h02, 8'h01, 8'h00, 8'h0B});
    check("t1_bi0", 64'(bi_out[2:0]), 64'd7);
    check("t1_ba0", 64'(ba_out[5:0]), 64'h01);
    check("t1_conflict", 64'(conflict), 64'd0);
    idle(2);
    send_one(2'd0, 1'b1, 1'b0, {8'h02, 8'h01, 8'h00, 8'h0B});
    check("t1_wrap_bi0", 64'(bi_out[2:0]), 64'd1);
    idle(2);

    // PWM inversion only on PE1
    send_one(PWM_OP0, 1'b0, 1'b0, {4{8'h0B}});
    check("t2_pwm_bi", 64'(bi_out), 64'({3'd1, 3'd1, 3'd7, 3'd7}));
    check("t2_pwm_ba", 64'(ba_out), 64'({6'h21, 6'h21, 6'h01, 6'h01}));
    idle(2);
    send_one(2'd1, 1'b0, 1'b0, {4{8'h0B}});
    check("t2_nopwm_bi", 64'(bi_out), 64'({3'd7, 3'd7, 3'd7, 3'd7}));
    check("t2_nopwm_ba", 64'(ba_out), 64'({6'h01, 6'h01, 6'h01, 6'h01}));
    idle(2);

    // Conflict detection and counting
    cnt_clr = 1'b1; @(posedge clk); #1 cnt_clr = 1'b0;
    check("t3_cleared", 64'(conflict_cnt), 64'd0);
    send_one(2'd0, 1'b0, 1'b0, {8'h02, 8'h01, 8'h0C, 8'h00});
    check("t3_conflict", 64'(conflict), 64'd1);
    @(posedge clk); #1;
    check("t3_cnt1", 64'(conflict_cnt), 64'd1);
    idle(1);
    send_one(2'd0, 1'b0, 1'b0, {8'h02, 8'h01, 8'h08, 8'h00});
    check("t3_noconflict", 64'(conflict), 64'd0);
    check("t3_noconflict_bi", 64'(bi_out), 64'({3'd2, 3'd1, 3'd4, 3'd0}));
    @(posedge clk); #1;
    check("t3_cnt_hold", 64'(conflict_cnt), 64'd1);
    idle(3);

    // 8 back-to-back beats at full throughput
    x0 = xfers;
    for (int i = 0; i < 8; i++) begin
      for (int l = 0; l < LANES; l++) v[l*ADDR_W +: ADDR_W] = 8'(i * 17 + l * 5);
      send(2'(i % 4), 1'(i % 2), 1'(i / 4), v);
    end
    idle(6);
    check("t4_xfers", 64'(xfers - x0), 64'd8);
    check("t4_run", 64'(last_run), 64'd8);

    // Back-pressure: exactly two beats fit while the output stalls
    x0 = xfers;
    out_ready = 1'b0;
    acc = 0;
    v = {8'hA3, 8'h5C, 8'h17, 8'hE2};
    opcode = 2'd3; mode = 1'b1; offset = 1'b0; addr_in = v; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      bit a;
      @(negedge clk);
      a = in_ready;
      if (a) acc++;
      @(posedge clk); #1;
      if (a) begin
        v = v + {8'h11, 8'h23, 8'h35, 8'h47};
        addr_in = v;
      end
    end
    check("t5_accepted", 64'(acc), 64'd2);
    check("t5_in_ready_low", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    send(opcode, mode, offset, addr_in);
    idle(6);
    check("t5_xfers", 64'(xfers - x0), 64'd3);
    check("t5_drained", 64'(exp_q.size()), 64'd0);

    // Saturation with a 4-bit counter, then clear beating an increment
    cnt_clr = 1'b1; @(posedge clk); #1 cnt_clr = 1'b0;
    for (int i = 0; i < 16; i++) send(2'd0, 1'b0, 1'b0, '0);
    idle(4);
    check("t6_saturated", 64'(conflict_cnt), 64'd15);
    send_one(2'd0, 1'b0, 1'b0, '0);
    check("t6_conflict", 64'(conflict), 64'd1);
    cnt_clr = 1'b1; @(posedge clk); #1 cnt_clr = 1'b0;
    check("t6_clr_priority", 64'(conflict_cnt), 64'd0);
    idle(2);

    // Asynchronous reset with both stages full
    send(2'd0, 1'b0, 1'b0, '0);
    send(2'd0, 1'b0, 1'b0, {8'h00, 8'h00, 8'h08, 8'h08});
    send(2'd0, 1'b0, 1'b0, {8'h10, 8'h10, 8'h00, 8'h00});
    check("t7_pre_valid", 64'(out_valid), 64'd1);
    check("t7_pre_cnt", 64'(conflict_cnt), 64'd1);
    #2 rst = 1'b0;
    exp_q.delete();
    cnt_model = 0;
    in_valid = 1'b0;
    #1;
    check("t7_valid", 64'(out_valid), 64'd0);
    check("t7_bi", 64'(bi_out), 64'd0);
    check("t7_ba", 64'(ba_out), 64'd0);
    check("t7_conflict", 64'(conflict), 64'd0);
    check("t7_cnt", 64'(conflict_cnt), 64'd0);
    @(posedge clk); #2 rst = 1'b1;
    idle(3);
    send_one(2'd0, 1'b0, 1'b0, {4{8'h0B}});
    check("t7_after_bi", 64'(bi_out), 64'({3'd7, 3'd7, 3'd7, 3'd7}));
    idle(4);
    check("final_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
